// File: rtl/calc_display_scan.sv
// Time-multiplexed 7-segment scanner for the calculator's BCD number format.
// Double-buffers the displayed value so the display only changes at frame boundaries.
module calc_display_scan #(
    parameter int NumDigits   = 8,
    parameter int RefreshDiv  = 1000,
    parameter int BlankCycles = 16,
    parameter int ActiveLow   = 0,
    parameter int ExpW        = $clog2(NumDigits)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     load_i,
    input  logic                     sign_i,
    input  logic                     error_i,
    input  logic [ExpW-1:0]          exponent_i,
    input  logic [4*NumDigits-1:0]   significand_i,
    output logic [6:0]               seg_o,
    output logic                     dp_o,
    output logic [NumDigits-1:0]     digit_en_o,
    output logic                     sign_o,
    output logic                     frame_o
);

    localparam int PW = $clog2(RefreshDiv);
    localparam int KW = $clog2(NumDigits);
    localparam logic [PW-1:0] PresLast = PW'(RefreshDiv - 1);
    localparam logic [PW-1:0] BlankEnd = PW'(BlankCycles);
    localparam logic [KW-1:0] SlotLast = KW'(NumDigits - 1);
    localparam logic          Inv      = (ActiveLow != 0);
    localparam logic [NumDigits-1:0] EnOne = {{(NumDigits-1){1'b0}}, 1'b1};

    function automatic logic [6:0] bcd2segments(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            default: s = 7'b1111011;
        endcase
        return s;
    endfunction

    logic [PW-1:0]          presc_r;
    logic [KW-1:0]          slot_r;
    logic                   pend_v_r;
    logic                   pend_sign_r;
    logic                   pend_err_r;
    logic [ExpW-1:0]        pend_exp_r;
    logic [4*NumDigits-1:0] pend_sig_r;
    logic                   shd_sign_r;
    logic                   shd_err_r;
    logic [ExpW-1:0]        shd_exp_r;
    logic [4*NumDigits-1:0] shd_sig_r;
    logic [6:0]             seg_r;
    logic                   dp_r;
    logic [NumDigits-1:0]   en_r;
    logic                   sign_r;
    logic                   frame_r;

    logic                   frame_start_s;
    logic                   take_s;
    logic                   eff_sign_s;
    logic                   eff_err_s;
    logic [ExpW-1:0]        eff_exp_s;
    logic [4*NumDigits-1:0] eff_sig_s;
    logic [NumDigits-1:0]   zero_below_s;
    logic [3:0]             nib_s;
    logic                   err_s;
    logic [6:0]             seg_s;
    logic                   dp_s;
    logic [NumDigits-1:0]   en_s;
    logic                   sign_s;

    assign frame_start_s = (slot_r == {KW{1'b0}}) && (presc_r == {PW{1'b0}});
    assign take_s        = frame_start_s & pend_v_r;

    // The first output of a frame already shows the value being swapped in.
    always_comb begin
        if (take_s) begin
            eff_sign_s = pend_sign_r;
            eff_err_s  = pend_err_r;
            eff_exp_s  = pend_exp_r;
            eff_sig_s  = pend_sig_r;
        end else begin
            eff_sign_s = shd_sign_r;
            eff_err_s  = shd_err_r;
            eff_exp_s  = shd_exp_r;
            eff_sig_s  = shd_sig_r;
        end
    end

    // zero_below_s[k] is set when nibbles k..0 are all zero.
    always_comb begin
        logic run;
        run          = 1'b1;
        zero_below_s = {NumDigits{1'b0}};
        for (int i = 0; i < NumDigits; i++) begin
            run             = run & (eff_sig_s[i*4 +: 4] == 4'd0);
            zero_below_s[i] = run;
        end
    end

    // Decode the active slot into segments, decimal point, enable and sign.
    always_comb begin
        int dp_pos;
        int slot_i;
        logic frac;
        slot_i = int'(slot_r);
        dp_pos = NumDigits - 1 - int'(eff_exp_s);
        nib_s  = eff_sig_s[slot_i*4 +: 4];
        err_s  = eff_err_s | (int'(eff_exp_s) > (NumDigits - 1));
        frac   = (slot_i < dp_pos);
        if (err_s) begin
            if (slot_r == SlotLast) begin
                seg_s = 7'b1001111;
            end else begin
                seg_s = 7'b0000000;
            end
            dp_s = 1'b0;
        end else begin
            if (frac && zero_below_s[slot_r]) begin
                seg_s = 7'b0000000;
            end else begin
                seg_s = bcd2segments(nib_s);
            end
            dp_s = (slot_i == dp_pos);
        end
        if (presc_r >= BlankEnd) begin
            en_s = EnOne << slot_r;
        end else begin
            en_s = {NumDigits{1'b0}};
        end
        sign_s = eff_sign_s & ~err_s;
    end

    // Prescaler and slot index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_r <= {PW{1'b0}};
            slot_r  <= {KW{1'b0}};
        end else if (presc_r == PresLast) begin
            presc_r <= {PW{1'b0}};
            if (slot_r == SlotLast) begin
                slot_r <= {KW{1'b0}};
            end else begin
                slot_r <= slot_r + KW'(1);
            end
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Pending buffer: a load in the frame-start cycle survives the swap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_v_r    <= 1'b0;
            pend_sign_r <= 1'b0;
            pend_err_r  <= 1'b0;
            pend_exp_r  <= {ExpW{1'b0}};
            pend_sig_r  <= {(4*NumDigits){1'b0}};
        end else if (load_i) begin
            pend_v_r    <= 1'b1;
            pend_sign_r <= sign_i;
            pend_err_r  <= error_i;
            pend_exp_r  <= exponent_i;
            pend_sig_r  <= significand_i;
        end else if (take_s) begin
            pend_v_r    <= 1'b0;
        end
    end

    // Shadow buffer: updated only at the frame start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shd_sign_r <= 1'b0;
            shd_err_r  <= 1'b0;
            shd_exp_r  <= {ExpW{1'b0}};
            shd_sig_r  <= {(4*NumDigits){1'b0}};
        end else if (take_s) begin
            shd_sign_r <= pend_sign_r;
            shd_err_r  <= pend_err_r;
            shd_exp_r  <= pend_exp_r;
            shd_sig_r  <= pend_sig_r;
        end
    end

    // Output register with polarity applied.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seg_r   <= {7{Inv}};
            dp_r    <= Inv;
            en_r    <= {NumDigits{Inv}};
            sign_r  <= 1'b0;
            frame_r <= 1'b0;
        end else begin
            seg_r   <= seg_s ^ {7{Inv}};
            dp_r    <= dp_s ^ Inv;
            en_r    <= en_s ^ {NumDigits{Inv}};
            sign_r  <= sign_s;
            frame_r <= frame_start_s;
        end
    end

    assign seg_o      = seg_r;
    assign dp_o       = dp_r;
    assign digit_en_o = en_r;
    assign sign_o     = sign_r;
    assign frame_o    = frame_r;

endmodule

// File: tb/tb_calc_display_scan.sv
// Directed bench for calc_display_scan (8 digits, 4 cycles/slot, 1 blank cycle),
// driving an active-high and an active-low instance from the same stimulus.
module tb_calc_display_scan;

    localparam logic [6:0] S0 = 7'b1111110;
    localparam logic [6:0] S1 = 7'b0110000;
    localparam logic [6:0] S2 = 7'b1101101;
    localparam logic [6:0] S3 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0110011;
    localparam logic [6:0] S5 = 7'b1011011;
    localparam logic [6:0] S6 = 7'b1011111;
    localparam logic [6:0] S7 = 7'b1110000;
    localparam logic [6:0] S8 = 7'b1111111;
    localparam logic [6:0] S9 = 7'b1111011;
    localparam logic [6:0] SE = 7'b1001111;
    localparam logic [6:0] SB = 7'b0000000;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic        sign;
    logic        err;
    logic [2:0]  expo;
    logic [31:0] sig;

    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [7:0]  en_a, en_b;
    logic        sign_a, sign_b;
    logic        frame_a, frame_b;

    int total;
    int bad;

    calc_display_scan #(.NumDigits(8), .RefreshDiv(4), .BlankCycles(1), .ActiveLow(0)) dut_hi (
        .clk_i(clk), .rst_ni(rst_n), .load_i(load), .sign_i(sign), .error_i(err),
        .exponent_i(expo), .significand_i(sig),
        .seg_o(seg_a), .dp_o(dp_a), .digit_en_o(en_a), .sign_o(sign_a), .frame_o(frame_a)
    );

    calc_display_scan #(.NumDigits(8), .RefreshDiv(4), .BlankCycles(1), .ActiveLow(1)) dut_lo (
        .clk_i(clk), .rst_ni(rst_n), .load_i(load), .sign_i(sign), .error_i(err),
        .exponent_i(expo), .significand_i(sig),
        .seg_o(seg_b), .dp_o(dp_b), .digit_en_o(en_b), .sign_o(sign_b), .frame_o(frame_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_val(input logic s, input logic e, input logic [2:0] x, input logic [31:0] v);
        sign = s;
        err  = e;
        expo = x;
        sig  = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    function automatic logic [55:0] pack(input logic [6:0] p7, input logic [6:0] p6,
                                         input logic [6:0] p5, input logic [6:0] p4,
                                         input logic [6:0] p3, input logic [6:0] p2,
                                         input logic [6:0] p1, input logic [6:0] p0);
        return {p7, p6, p5, p4, p3, p2, p1, p0};
    endfunction

    // Find the next frame start, then check all 32 cycles of that frame on both instances.
    task automatic walk(input logic [55:0] segs, input logic [7:0] dps, input logic sgn);
        int i;
        int k;
        int p;
        logic [6:0] es;
        logic [7:0] een;
        logic       edp;
        i = 0;
        while (i < 80 && frame_a !== 1'b1) begin
            @(negedge clk);
            i++;
        end
        check("frame_found", {31'b0, frame_a}, 32'd1);
        for (int c = 0; c < 32; c++) begin
            k   = c / 4;
            p   = c % 4;
            es  = segs[k*7 +: 7];
            edp = dps[k];
            een = (p >= 1) ? 8'(1 << k) : 8'h00;
            check("seg",    {25'b0, seg_a}, {25'b0, es});
            check("dp",     {31'b0, dp_a}, {31'b0, edp});
            check("en",     {24'b0, en_a}, {24'b0, een});
            check("sign",   {31'b0, sign_a}, {31'b0, sgn});
            check("frame",  {31'b0, frame_a}, (c == 0) ? 32'd1 : 32'd0);
            check("seg_lo", {25'b0, seg_b}, {25'b0, ~es});
            check("dp_lo",  {31'b0, dp_b}, {31'b0, ~edp});
            check("en_lo",  {24'b0, en_b}, {24'b0, ~een});
            @(negedge clk);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clk   = 1'b0;
        rst_n = 1'b0;
        load  = 1'b0;
        sign  = 1'b0;
        err   = 1'b0;
        expo  = 3'd0;
        sig   = 32'h0;

        // Reset values on both polarities.
        step(2);
        check("rst_seg",    {25'b0, seg_a}, 32'h00);
        check("rst_dp",     {31'b0, dp_a}, 32'd0);
        check("rst_en",     {24'b0, en_a}, 32'h00);
        check("rst_sign",   {31'b0, sign_a}, 32'd0);
        check("rst_frame",  {31'b0, frame_a}, 32'd0);
        check("rst_seg_lo", {25'b0, seg_b}, 32'h7f);
        check("rst_dp_lo",  {31'b0, dp_b}, 32'd1);
        check("rst_en_lo",  {24'b0, en_b}, 32'hff);
        check("rst_frm_lo", {31'b0, frame_b}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_frame1", {31'b0, frame_a}, 32'd1);
        check("rel_en1",    {24'b0, en_a}, 32'h00);
        @(negedge clk);
        check("rel_en2",    {24'b0, en_a}, 32'h01);
        check("rel_frame2", {31'b0, frame_a}, 32'd0);

        // Zero value after reset: "0." on position 7.
        walk(pack(S0, SB, SB, SB, SB, SB, SB, SB), 8'h80, 1'b0);

        // 1.2345000, exponent 0.
        load_val(1'b0, 1'b0, 3'd0, 32'h12345000);
        walk(pack(S1, S2, S3, S4, S5, SB, SB, SB), 8'h80, 1'b0);

        // 1230. with sign.
        load_val(1'b1, 1'b0, 3'd3, 32'h12300000);
        walk(pack(S1, S2, S3, S0, SB, SB, SB, SB), 8'h10, 1'b1);

        // Error suppresses the sign.
        load_val(1'b1, 1'b1, 3'd0, 32'h12345678);
        walk(pack(SE, SB, SB, SB, SB, SB, SB, SB), 8'h00, 1'b0);

        // Interior zero stays visible; trailing zeros blank.
        load_val(1'b0, 1'b0, 3'd0, 32'h10200000);
        walk(pack(S1, S0, S2, SB, SB, SB, SB, SB), 8'h80, 1'b0);

        // Maximum exponent, non-BCD nibble renders as 9.
        load_val(1'b0, 1'b0, 3'd7, 32'h0000000F);
        walk(pack(S0, S0, S0, S0, S0, S0, S0, S9), 8'h01, 1'b0);

        // Two loads in one frame: only the later one is shown.
        step(4);
        load_val(1'b0, 1'b0, 3'd0, 32'h99999999);
        step(14);
        load_val(1'b0, 1'b0, 3'd2, 32'h76543210);
        walk(pack(S7, S6, S5, S4, S3, S2, S1, SB), 8'h20, 1'b0);

        // Load coinciding with frame start is deferred; the older pending value shows first.
        step(10);
        load_val(1'b1, 1'b0, 3'd1, 32'h00000000);
        step(20);
        load_val(1'b0, 1'b0, 3'd0, 32'h80000009);
        walk(pack(S0, S0, SB, SB, SB, SB, SB, SB), 8'h40, 1'b1);
        walk(pack(S8, S0, S0, S0, S0, S0, S0, S9), 8'h80, 1'b0);

        // Asynchronous reset asserted mid-slot.
        step(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_seg_lo", {25'b0, seg_b}, 32'h7f);
        check("mid_dp_lo",  {31'b0, dp_b}, 32'd1);
        check("mid_en_lo",  {24'b0, en_b}, 32'hff);
        check("mid_seg",    {25'b0, seg_a}, 32'h00);
        check("mid_en",     {24'b0, en_a}, 32'h00);
        check("mid_sign",   {31'b0, sign_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst2_frame", {31'b0, frame_a}, 32'd1);
        check("rst2_seg",   {25'b0, seg_a}, 32'h00);
        check("rst2_en_lo", {24'b0, en_b}, 32'hff);
        @(negedge clk);
        check("rst2_en",    {24'b0, en_a}, 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
